// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: program counter plus a single-outstanding instruction fetch FSM (FETCH/WAIT/ISSUE/RESOLVE).
// Latency: instr_valid no earlier than 2 cycles after FETCH entry; FETCH re-entered 1 cycle after next-PC resolve.
// Backpressure: holds instr/instr_pc while instr_ready=0; no prefetch. Optional macro MISALIGN_TRAP_EN.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        br_valid,
    input  logic [12:0] br_incr,
    input  logic        jmp_valid,
    input  logic [31:0] jmp_target
`ifdef MISALIGN_TRAP_EN
    ,
    output logic        misalign
`endif
);

    localparam logic [1:0] FETCH   = 2'd0;
    localparam logic [1:0] WAIT    = 2'd1;
    localparam logic [1:0] ISSUE   = 2'd2;
    localparam logic [1:0] RESOLVE = 2'd3;

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] next_pc;

    // Jump target takes priority over the sign-extended branch increment.
    always_comb begin
        next_pc = pc + {{19{br_incr[12]}}, br_incr};
        if (jmp_valid) begin
            next_pc = jmp_target;
        end
    end

    assign imem_req  = (state == FETCH);
    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            instr_valid <= 1'b0;
            instr       <= 32'h0;
            instr_pc    <= 32'h0;
`ifdef MISALIGN_TRAP_EN
            misalign    <= 1'b0;
`endif
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        instr       <= imem_rdata;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        state       <= RESOLVE;
                    end
                end
                RESOLVE: begin
                    if (br_valid || jmp_valid) begin
`ifdef MISALIGN_TRAP_EN
                        // Once trapped, the sequencer stays parked in RESOLVE until reset.
                        if (!misalign) begin
                            pc <= next_pc;
                            if (next_pc[1:0] != 2'b00) begin
                                misalign <= 1'b1;
                            end else begin
                                state <= FETCH;
                            end
                        end
`else
                        pc    <= next_pc & ~32'h3;
                        state <= FETCH;
`endif
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Scoreboard bench for pc_fetch_sequencer: directed corner cases followed by randomized fetch/resolve traffic.
module tb_pc_fetch_sequencer;

    localparam logic [31:0] RST = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic        br_valid = 1'b0;
    logic [12:0] br_incr = 13'h0;
    logic        jmp_valid = 1'b0;
    logic [31:0] jmp_target = 32'h0;
`ifdef MISALIGN_TRAP_EN
    logic        misalign;
`endif

    pc_fetch_sequencer #(.RESET_PC(RST)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .br_valid    (br_valid),
        .br_incr     (br_incr),
        .jmp_valid   (jmp_valid),
        .jmp_target  (jmp_target)
`ifdef MISALIGN_TRAP_EN
        ,
        .misalign    (misalign)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    logic [31:0] exp_addr_q[$];
    logic [63:0] exp_instr_q[$];
    logic [31:0] model_pc;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: pops the expected address/instruction whenever a handshake is about to complete.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (reset_n && imem_req && imem_ready) begin
                if (exp_addr_q.size() == 0) begin
                    checks++;
                    $display("FAIL fetch_extra: got request at %h expected none", imem_addr);
                end else begin
                    chk("fetch_addr", imem_addr, exp_addr_q.pop_front());
                end
            end
            if (reset_n && instr_valid && instr_ready) begin
                if (exp_instr_q.size() == 0) begin
                    checks++;
                    $display("FAIL instr_extra: got instr %h at %h expected none", instr, instr_pc);
                end else begin
                    e = exp_instr_q.pop_front();
                    chk("instr_pc", instr_pc, e[63:32]);
                    chk("instr_word", instr, e[31:0]);
                end
            end
        end
    end

    task automatic do_instr(input bit rnd, input bit jv, input bit bv, input logic [12:0] incr,
                            input logic [31:0] tgt, input int stall, input bit halt);
        int cyc, vcyc, first, d;
        bit seen, done;
        logic [31:0] np;
        exp_addr_q.push_back(model_pc);
        exp_instr_q.push_back({model_pc, memword(model_pc)});
        imem_rdata = memword(model_pc);
        cyc = 0; vcyc = 0; first = -1; seen = 0; done = 0;
        while (!done && cyc < 300) begin
            @(negedge clk);
            if (seen) vcyc++;
            else if (instr_valid) begin
                seen  = 1;
                first = cyc;
            end
            if (seen && vcyc > 0 && !rnd) begin
                chk("hold_valid", 32'(instr_valid), 32'd1);
                chk("hold_instr", instr, memword(model_pc));
                chk("hold_pc", instr_pc, model_pc);
            end
            imem_ready  = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            imem_rvalid = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            instr_ready = rnd ? ($urandom_range(0, 2) != 0) : (seen && vcyc >= stall);
            // Next-PC inputs outside RESOLVE carry junk that must be ignored.
            br_valid    = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            br_incr     = 13'($urandom);
            jmp_valid   = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            jmp_target  = $urandom;
            #1;
            done = instr_valid && instr_ready;
            cyc++;
        end
        if (!done) begin
            checks++;
            $display("FAIL issue_timeout: got no decode handshake in %0d cycles expected one", cyc);
        end
        if (!rnd) chk("fetch_latency", 32'(first), 32'd2);

        d = rnd ? $urandom_range(0, 3) : 0;
        repeat (d) begin
            @(negedge clk);
            br_valid    = 1'b0;
            jmp_valid   = 1'b0;
            imem_ready  = 1'($urandom_range(0, 1));
            imem_rvalid = 1'($urandom_range(0, 1));
            instr_ready = 1'($urandom_range(0, 1));
            #1;
            chk("resolve_req", 32'(imem_req), 32'd0);
            chk("resolve_valid", 32'(instr_valid), 32'd0);
        end

        @(negedge clk);
        br_valid   = bv;
        jmp_valid  = jv;
        br_incr    = incr;
        jmp_target = tgt;
        np = jv ? tgt : model_pc + 32'($signed(incr));
`ifdef MISALIGN_TRAP_EN
        model_pc = np;
`else
        model_pc = {np[31:2], 2'b00};
`endif
        @(negedge clk);
        br_valid    = 1'b0;
        jmp_valid   = 1'b0;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        #1;
        if (halt) begin
`ifdef MISALIGN_TRAP_EN
            repeat (4) begin
                chk("trap_misalign", 32'(misalign), 32'd1);
                chk("trap_req", 32'(imem_req), 32'd0);
                @(negedge clk);
                imem_ready = 1'b1;
                br_valid   = 1'b1;
                br_incr    = 13'd2;
                #1;
            end
            imem_ready = 1'b0;
            br_valid   = 1'b0;
`endif
        end else begin
            chk("refetch_req", 32'(imem_req), 32'd1);
            if (!rnd) chk("refetch_addr", imem_addr, model_pc);
        end
    endtask

    task automatic reset_in_wait();
        exp_addr_q.push_back(model_pc);
        exp_instr_q.push_back({model_pc, memword(model_pc)});
        imem_rdata = memword(model_pc);
        @(negedge clk);
        imem_ready  = 1'b1;
        imem_rvalid = 1'b0;
        @(negedge clk);
        imem_ready = 1'b0;
        reset_n    = 1'b0;
        exp_addr_q.delete();
        exp_instr_q.delete();
        model_pc = RST;
        #1;
        chk("rst_wait_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        reset_n     = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        #1;
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_addr", imem_addr, RST);
        chk("rst_req", 32'(imem_req), 32'd1);
        @(negedge clk);
        imem_rvalid = 1'b0;
        #1;
        chk("rst_late_rvalid", 32'(instr_valid), 32'd0);
    endtask

    initial begin
        logic [12:0] inc;
        logic [31:0] t;
        bit          j, b;
        model_pc = RST;
        @(negedge clk);
        #1;
        chk("reset_req", 32'(imem_req), 32'd1);
        chk("reset_addr", imem_addr, RST);
        chk("reset_valid", 32'(instr_valid), 32'd0);
        chk("reset_instr", instr, 32'h0);
        chk("reset_instr_pc", instr_pc, 32'h0);
`ifdef MISALIGN_TRAP_EN
        chk("reset_misalign", 32'(misalign), 32'd0);
`endif
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        do_instr(0, 0, 1, 13'd4, 32'h0, 0, 0);
        do_instr(0, 0, 1, 13'h1FF8, 32'h0, 0, 0);
        do_instr(0, 1, 1, 13'd4, 32'h0000_2000, 5, 0);
        do_instr(0, 1, 0, 13'd0, 32'hFFFF_FFFC, 0, 0);
        do_instr(0, 0, 1, 13'd4, 32'h0, 0, 0);
        do_instr(0, 0, 1, 13'd0, 32'h0, 0, 0);
`ifndef MISALIGN_TRAP_EN
        do_instr(0, 0, 1, 13'd6, 32'h0, 0, 0);
        do_instr(0, 1, 0, 13'd0, 32'h0000_2003, 0, 0);
`endif
        reset_in_wait();

        for (int i = 0; i < 150; i++) begin
            j   = ($urandom_range(0, 2) == 0);
            b   = j ? 1'($urandom_range(0, 1)) : 1'b1;
            inc = 13'($urandom);
            t   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
`ifdef MISALIGN_TRAP_EN
            inc[1:0] = 2'b00;
            t[1:0]   = 2'b00;
`endif
            do_instr(1, j, b, inc, t, 0, 0);
        end

`ifdef MISALIGN_TRAP_EN
        do_instr(0, 0, 1, 13'd2, 32'h0, 0, 1);
`endif
        repeat (4) @(negedge clk);
        chk("addr_q_drained", 32'(exp_addr_q.size()), 32'd0);
        chk("instr_q_drained", 32'(exp_instr_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
